// File: rtl/fetch_sequencer_if.sv
// Bundles the instruction-memory handshake, decode handshake and fetch control
// signals used by fetch_sequencer.
interface fetch_sequencer_if;
  logic        en;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready;
  logic        busy;

  modport slave (
    input  en, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    output imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, busy
  );

  modport master (
    output en, redirect_valid, redirect_pc, imem_req_ready, imem_rsp_valid,
           imem_rsp_data, inst_ready,
    input  imem_req_valid, imem_req_addr, inst_valid, inst_pc, inst_data, busy
  );
endinterface

// File: rtl/fetch_sequencer.sv
// PC sequencer for a variable-latency instruction memory with one outstanding
// request, redirect handling and a 2-entry {pc, instruction} buffer to decode.
module fetch_sequencer #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          BUF_DEPTH = 2
) (
  input logic              clk,
  input logic              rst,
  fetch_sequencer_if.slave bus
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] WAIT = 2'd2;
  localparam logic [1:0] FULL = 2'(BUF_DEPTH);

  logic [1:0]  state, stateNext;
  logic [31:0] fetchPc, reqPc, redirectTarget;
  logic        drop;
  logic [1:0]  count, countNext;
  logic [31:0] headPc, headData, tailPc, tailData;
  logic        handshake, rspTaken, push, pop, space;

  assign redirectTarget = bus.redirect_pc & 32'hFFFF_FFFC;
  assign handshake      = (state == REQ) & bus.imem_req_ready;
  assign rspTaken       = (state == WAIT) & bus.imem_rsp_valid;
  assign push           = rspTaken & ~drop & ~bus.redirect_valid;
  assign pop            = (count != 2'd0) & bus.inst_ready & ~bus.redirect_valid;

  // Occupancy after this cycle; includes an incoming push so a request is never
  // issued without a free slot for its response.
  always_comb begin
    countNext = count;
    if (bus.redirect_valid)
      countNext = 2'd0;
    else if (push && !pop)
      countNext = count + 2'd1;
    else if (pop && !push)
      countNext = count - 2'd1;
  end

  assign space = (countNext < FULL);

  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (!bus.redirect_valid && bus.en && space) stateNext = REQ;
      REQ: begin
        if (handshake)
          stateNext = WAIT;
        else if (!bus.en)
          stateNext = IDLE;
      end
      WAIT: if (rspTaken) stateNext = (bus.en && space) ? REQ : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // Redirect wins over +4; drop marks the in-flight response as stale.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      fetchPc <= RESET_PC;
      reqPc   <= 32'h0;
      drop    <= 1'b0;
    end else begin
      state <= stateNext;
      if (bus.redirect_valid)
        fetchPc <= redirectTarget;
      else if (handshake)
        fetchPc <= fetchPc + 32'd4;
      if (handshake) begin
        reqPc <= fetchPc;
        drop  <= bus.redirect_valid;
      end else if (rspTaken) begin
        drop <= 1'b0;
      end else if (state == WAIT && bus.redirect_valid) begin
        drop <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= 2'd0;
      headPc   <= 32'h0;
      headData <= 32'h0;
      tailPc   <= 32'h0;
      tailData <= 32'h0;
    end else begin
      count <= countNext;
      if (push && (count == 2'd0 || (count == 2'd1 && pop))) begin
        headPc   <= reqPc;
        headData <= bus.imem_rsp_data;
      end else if (pop) begin
        headPc   <= tailPc;
        headData <= tailData;
      end
      if (push && ((count == 2'd1 && !pop) || (count == 2'd2 && pop))) begin
        tailPc   <= reqPc;
        tailData <= bus.imem_rsp_data;
      end
    end
  end

  assign bus.imem_req_valid = (state == REQ);
  assign bus.imem_req_addr  = fetchPc;
  assign bus.inst_valid     = (count != 2'd0);
  assign bus.inst_pc        = headPc;
  assign bus.inst_data      = headData;
  assign bus.busy           = (state != IDLE);

endmodule
